// File: rtl/instr_fetch_unit_if.sv
// Instruction-cache request/response bundle between the fetch unit (master) and the icache (slave).
interface instr_fetch_unit_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;

  modport master (
    output imemREN,
    output imemaddr,
    input  ihit,
    input  imemload
  );

  modport slave (
    input  imemREN,
    input  imemaddr,
    output ihit,
    output imemload
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues icache word reads, fills the IF/ID register and steers the PC.
// Define FETCH_STATS_EN to build the saturating fetch/stall/squash perf counters.
module instr_fetch_unit #(
  parameter int unsigned PC_INC = 4,
  parameter int unsigned STAT_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [31:0]          pc_out,
  output logic [31:0]          pc_in,
  output logic                 pc_WEN,
  instr_fetch_unit_if.master   imem,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  input  logic                 halt,
  output logic                 ifid_valid,
  output logic [31:0]          ifid_instr,
  output logic [31:0]          ifid_npc,
  output logic [STAT_W-1:0]    fetch_cnt,
  output logic [STAT_W-1:0]    stall_cnt,
  output logic [STAT_W-1:0]    squash_cnt
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] tgt_q, tgt_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_npc_q, ifid_npc_d;
  logic [31:0] seq_addr;
  logic        imem_ren;

  assign seq_addr = req_addr_q + 32'(PC_INC);

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    tgt_d        = tgt_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_npc_d   = ifid_npc_q;
    imem_ren     = 1'b0;
    pc_WEN       = 1'b0;
    pc_in        = seq_addr;

    unique case (state_q)
      StIdle: begin
        req_addr_d = pc_out;
        state_d    = halt ? StHalted : StFetch;
      end

      StFetch: begin
        imem_ren = !(ifid_valid_q && stall);
        if (redirect) begin
          pc_WEN       = 1'b1;
          pc_in        = redirect_pc;
          ifid_valid_d = 1'b0;
          // An unanswered request must be drained before the target can be issued.
          if (imem_ren && !imem.ihit) begin
            tgt_d   = redirect_pc;
            state_d = StDrain;
          end else begin
            req_addr_d = redirect_pc;
          end
        end else if (halt) begin
          // Let the outstanding request finish, but never use its data.
          if (!imem_ren || imem.ihit) begin
            ifid_valid_d = 1'b0;
            state_d      = StHalted;
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
          end
        end else if (imem_ren && imem.ihit) begin
          ifid_instr_d = imem.imemload;
          ifid_npc_d   = seq_addr;
          ifid_valid_d = 1'b1;
          pc_WEN       = 1'b1;
          req_addr_d   = seq_addr;
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
        end
      end

      StDrain: begin
        imem_ren     = 1'b1;
        ifid_valid_d = 1'b0;
        if (redirect) begin
          pc_WEN = 1'b1;
          pc_in  = redirect_pc;
          tgt_d  = redirect_pc;
        end
        if (imem.ihit) begin
          req_addr_d = redirect ? redirect_pc : tgt_q;
          state_d    = halt ? StHalted : StFetch;
        end
      end

      StHalted: begin
        ifid_valid_d = 1'b0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      req_addr_q   <= '0;
      tgt_q        <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_npc_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      tgt_q        <= tgt_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_npc_q   <= ifid_npc_d;
    end
  end

  assign imem.imemREN  = imem_ren;
  assign imem.imemaddr = req_addr_q;
  assign ifid_valid    = ifid_valid_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_npc      = ifid_npc_q;

`ifdef FETCH_STATS_EN
  logic [STAT_W-1:0] fetch_cnt_q, stall_cnt_q, squash_cnt_q;
  logic              ev_fetch, ev_stall, ev_squash;

  // The only non-redirect PC write is an accepted hit.
  assign ev_fetch  = pc_WEN && !redirect;
  assign ev_squash = pc_WEN && redirect;
  assign ev_stall  = imem_ren && !imem.ihit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (ev_fetch && (fetch_cnt_q != '1)) begin
        fetch_cnt_q <= fetch_cnt_q + STAT_W'(1);
      end
      if (ev_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      end
      if (ev_squash && (squash_cnt_q != '1)) begin
        squash_cnt_q <= squash_cnt_q + STAT_W'(1);
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign squash_cnt = squash_cnt_q;
`else
  assign fetch_cnt  = '0;
  assign stall_cnt  = '0;
  assign squash_cnt = '0;
`endif

endmodule
